// File: rtl/mux_guard_pkg.sv
// Shared types and helpers for the mux address guard.
package mux_guard_pkg;

    // Guard FSM states
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ON     = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    // Flat index of the unordered channel pair (i<j) among n channels
    function automatic int pair_idx(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/adr_conflict_detect.sv
// Combinational pairwise address-collision detector across NCH channels.
module adr_conflict_detect
    import mux_guard_pkg::*;
#(
    parameter int NCH  = 3,
    parameter int ADRW = 4
) (
    input  logic [NCH*ADRW-1:0] adr,
    output logic                conflict
);

    localparam int NPAIR = NCH * (NCH - 1) / 2;

    logic [NPAIR-1:0] pair_eq;

    // One equality comparator per unordered channel pair
    for (genvar i = 0; i < NCH - 1; i++) begin : g_i
        for (genvar j = i + 1; j < NCH; j++) begin : g_j
            assign pair_eq[pair_idx(i, j, NCH)] =
                (adr[i*ADRW +: ADRW] == adr[j*ADRW +: ADRW]);
        end
    end

    assign conflict = |pair_eq;

endmodule

// File: rtl/mux_guard.sv
// Mux-address protection: collision gating, break-before-make settle
// sequencing and collision lockout with sticky flag and event counter.
// All outputs are registered from the current state, so each FSM
// transition becomes visible on the outputs one edge after it is taken.
module mux_guard
    import mux_guard_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int ADRW   = 4,
    parameter int SETTLE = 4,
    parameter int CNTW   = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NCH*ADRW-1:0] adr_in,
    input  logic                mux_en_in,
    input  logic                fault_clr,
    output logic [NCH*ADRW-1:0] adr_out,
    output logic                mux_en_out,
    output logic                settling,
    output logic                locked,
    output logic                fault_sticky,
    output logic [CNTW-1:0]     conflict_cnt
);

    localparam int TW = $clog2(SETTLE + 1);

    state_t          state, state_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic            conflict;
    logic            qc;
    logic            qc_q;
    logic            qc_rise;
    logic            change;

    adr_conflict_detect #(
        .NCH  (NCH),
        .ADRW (ADRW)
    ) u_detect (
        .adr      (adr_in),
        .conflict (conflict)
    );

    // A collision only matters when the sequencer is asking for the mux
    assign qc      = conflict & mux_en_in;
    assign qc_rise = qc & ~qc_q;
    assign change  = (adr_in != adr_out);

    // Next-state and settle-timer logic
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        unique case (state)
            ST_OFF: begin
                if (qc) begin
                    state_nxt = ST_LOCK;
                end else if (mux_en_in) begin
                    state_nxt = ST_SETTLE;
                    timer_nxt = TW'(SETTLE);
                end
            end
            ST_SETTLE: begin
                if (qc) begin
                    state_nxt = ST_LOCK;
                end else if (!mux_en_in || change) begin
                    state_nxt = ST_OFF;
                end else if (timer == TW'(1)) begin
                    state_nxt = ST_ON;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            ST_ON: begin
                if (qc) begin
                    state_nxt = ST_LOCK;
                end else if (!mux_en_in || change) begin
                    state_nxt = ST_OFF;
                end
            end
            ST_LOCK: begin
                // Re-arm only after the requester drops enable
                if (!mux_en_in) begin
                    state_nxt = ST_OFF;
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    // State and settle-timer registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_OFF;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Registered mux-side outputs; addresses only track while the mux is off
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            adr_out    <= '0;
            mux_en_out <= 1'b0;
            settling   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            mux_en_out <= (state == ST_ON);
            settling   <= (state == ST_SETTLE);
            locked     <= (state == ST_LOCK);
            if (state == ST_OFF || state == ST_LOCK) begin
                adr_out <= adr_in;
            end
        end
    end

    // Fault history: a fresh conflict beats a same-cycle clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            qc_q         <= 1'b0;
            fault_sticky <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            qc_q <= qc;
            if (qc) begin
                fault_sticky <= 1'b1;
            end else if (fault_clr) begin
                fault_sticky <= 1'b0;
            end
            if (fault_clr) begin
                conflict_cnt <= qc_rise ? CNTW'(1) : '0;
            end else if (qc_rise && conflict_cnt != {CNTW{1'b1}}) begin
                conflict_cnt <= conflict_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_guard.sv
// Scoreboard bench for mux_guard: a behavioural model pushes the expected
// post-edge outputs into a queue, which is popped and compared after each edge.
module tb_mux_guard;

    localparam int NCH    = 3;
    localparam int ADRW   = 4;
    localparam int SETTLE = 4;
    // Narrow counter so saturation is reachable in a short run
    localparam int CNTW   = 8;

    logic                clock = 1'b0;
    logic                reset;
    logic [NCH*ADRW-1:0] adr_in;
    logic                mux_en_in;
    logic                fault_clr;
    logic [NCH*ADRW-1:0] adr_out;
    logic                mux_en_out;
    logic                settling;
    logic                locked;
    logic                fault_sticky;
    logic [CNTW-1:0]     conflict_cnt;

    mux_guard #(
        .NCH    (NCH),
        .ADRW   (ADRW),
        .SETTLE (SETTLE),
        .CNTW   (CNTW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .adr_in       (adr_in),
        .mux_en_in    (mux_en_in),
        .fault_clr    (fault_clr),
        .adr_out      (adr_out),
        .mux_en_out   (mux_en_out),
        .settling     (settling),
        .locked       (locked),
        .fault_sticky (fault_sticky),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NCH*ADRW-1:0] adr;
        logic                en;
        logic                set;
        logic                lock;
        logic                fault;
        logic [CNTW-1:0]     cnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // model state: 0 off, 1 settle, 2 on, 3 lock
    int                  m_st;
    int                  m_tmr;
    logic [NCH*ADRW-1:0] m_adr;
    logic                m_en, m_set, m_lock, m_fault, m_qcq;
    logic [CNTW-1:0]     m_cnt;
    logic                prev_en;
    logic [NCH*ADRW-1:0] prev_adr;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_tmr = 0; m_adr = '0; m_en = 0; m_set = 0; m_lock = 0;
        m_fault = 0; m_qcq = 0; m_cnt = '0;
        prev_en = 0; prev_adr = '0;
    endtask

    task automatic model_edge();
        logic [3:0] a0, a1, a2;
        logic conf, qc, chg, inc;
        a0 = adr_in[3:0]; a1 = adr_in[7:4]; a2 = adr_in[11:8];
        conf = (a0 == a1) || (a0 == a2) || (a1 == a2);
        qc   = conf && mux_en_in;
        chg  = (adr_in != m_adr);
        inc  = qc && !m_qcq;
        m_en   = (m_st == 2);
        m_set  = (m_st == 1);
        m_lock = (m_st == 3);
        if (m_st == 0 || m_st == 3) m_adr = adr_in;
        case (m_st)
            0: if (qc) m_st = 3; else if (mux_en_in) begin m_st = 1; m_tmr = SETTLE; end
            1: if (qc) m_st = 3; else if (!mux_en_in || chg) m_st = 0;
               else if (m_tmr == 1) m_st = 2; else m_tmr = m_tmr - 1;
            2: if (qc) m_st = 3; else if (!mux_en_in || chg) m_st = 0;
            default: if (!mux_en_in) m_st = 0;
        endcase
        if (qc) m_fault = 1; else if (fault_clr) m_fault = 0;
        if (fault_clr) m_cnt = inc ? CNTW'(1) : '0;
        else if (inc && m_cnt != {CNTW{1'b1}}) m_cnt = m_cnt + CNTW'(1);
        m_qcq = qc;
    endtask

    // One clock: model the edge, queue the expectation, compare after the edge
    task automatic step();
        obs_t e;
        @(posedge clock);
        model_edge();
        exp_q.push_back({m_adr, m_en, m_set, m_lock, m_fault, m_cnt});
        #1;
        e = exp_q.pop_front();
        check("adr_out",      32'(adr_out),      32'(e.adr));
        check("mux_en_out",   32'(mux_en_out),   32'(e.en));
        check("settling",     32'(settling),     32'(e.set));
        check("locked",       32'(locked),       32'(e.lock));
        check("fault_sticky", 32'(fault_sticky), 32'(e.fault));
        check("conflict_cnt", 32'(conflict_cnt), 32'(e.cnt));
        if (prev_en && mux_en_out) check("bbm_adr_hold", 32'(adr_out), 32'(prev_adr));
        prev_en  = mux_en_out;
        prev_adr = adr_out;
    endtask

    task automatic set_adr(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        adr_in = {a2, a1, a0};
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_adr"},   32'(adr_out),      32'h0);
        check({tag, "_en"},    32'(mux_en_out),   32'h0);
        check({tag, "_set"},   32'(settling),     32'h0);
        check({tag, "_lock"},  32'(locked),       32'h0);
        check({tag, "_fault"}, 32'(fault_sticky), 32'h0);
        check({tag, "_cnt"},   32'(conflict_cnt), 32'h0);
    endtask

    // Async reset pulse started just after a sample point
    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        check_all_zero(tag);
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    // Edge k counts from the edge that first samples enable with clean addresses
    task automatic settle_seq(input string tag);
        for (int k = 0; k <= 6; k++) begin
            step();
            check({tag, "_settling"}, 32'(settling),   32'((k >= 1 && k <= 4) ? 1 : 0));
            check({tag, "_en"},       32'(mux_en_out), 32'((k >= 5) ? 1 : 0));
        end
    endtask

    initial begin
        reset = 1'b1; mux_en_in = 0; fault_clr = 0; adr_in = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        reset = 1'b0;
        #1;

        // Bring-up with distinct addresses
        set_adr(1, 2, 3); mux_en_in = 1;
        settle_seq("bringup");
        check("bringup_adr", 32'(adr_out), 32'h321);

        // Address change while on: break, reload, settle again
        set_adr(5, 2, 3);
        for (int k = 0; k <= 6; k++) begin
            step();
            if (k == 1) begin
                check("chg_en_drop", 32'(mux_en_out), 32'h0);
                check("chg_adr",     32'(adr_out),    32'h325);
            end
            if (k == 5) check("chg_en_low", 32'(mux_en_out), 32'h0);
            if (k == 6) check("chg_en_back", 32'(mux_en_out), 32'h1);
        end

        // Collision while on -> lockout
        set_adr(5, 3, 3);
        step(); step();
        check("lock_locked", 32'(locked),       32'h1);
        check("lock_en",     32'(mux_en_out),   32'h0);
        check("lock_fault",  32'(fault_sticky), 32'h1);
        check("lock_cnt",    32'(conflict_cnt), 32'h1);
        set_adr(5, 2, 3);
        repeat (3) step();
        check("lock_hold", 32'(locked), 32'h1);
        mux_en_in = 0;
        step(); step();
        check("lock_exit", 32'(locked), 32'h0);

        // Clear, then collisions with enable low are ignored
        fault_clr = 1; step(); fault_clr = 0;
        set_adr(7, 7, 7);
        repeat (3) step();
        check("idle_conf_cnt",   32'(conflict_cnt), 32'h0);
        check("idle_conf_fault", 32'(fault_sticky), 32'h0);
        check("idle_conf_adr",   32'(adr_out),      32'h777);
        check("idle_conf_en",    32'(mux_en_out),   32'h0);

        // Drive the counter into saturation, then one more edge
        mux_en_in = 1;
        for (int n = 0; n < 260; n++) begin
            set_adr(7, 7, 7); step();
            set_adr(1, 2, 3); step();
        end
        check("sat_cnt", 32'(conflict_cnt), 32'hFF);
        set_adr(7, 7, 7); step();
        check("sat_hold", 32'(conflict_cnt), 32'hFF);
        set_adr(1, 2, 3); step();
        // Clear racing a new conflict edge
        set_adr(7, 7, 7); fault_clr = 1; step(); fault_clr = 0;
        check("clr_race_fault", 32'(fault_sticky), 32'h1);
        check("clr_race_cnt",   32'(conflict_cnt), 32'h1);

        // Leave lock, reset mid-settle, then full sequence again
        mux_en_in = 0; set_adr(1, 2, 3);
        step(); step();
        mux_en_in = 1;
        step(); step();
        check("pre_rst_settling", 32'(settling), 32'h1);
        async_reset("rst_settle");
        settle_seq("resettle");
        async_reset("rst_on");
        settle_seq("reon");

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0)
                set_adr(4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
            if ($urandom_range(0, 9) == 0) mux_en_in = ~mux_en_in;
            fault_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        fault_clr = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
